// File: rtl/aska_spi_master.sv
// SPI mode-0 master that sends one {addr, data} frame per accepted request,
// MSB first, framed by an active-low chip select and followed by a fixed
// chip-select-high gap.
module aska_spi_master #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 2,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_data,
  output logic              req_ready,
  output logic              done,
  output logic              busy,
  output logic              SPI_CS,
  output logic              SPI_Clk,
  output logic              SPI_MOSI
);

  localparam int N  = ADDR_W + WORD_W;
  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  // Holds the bits still to be sent after the one currently on MOSI.
  logic [N-2:0]  shreg;
  logic [N-1:0]  frame;

  assign frame = {req_addr, req_data};

  // Frame sequencer; every pin is registered and set on the edge that enters
  // the state it belongs to, so pin timing matches the state timing exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      SPI_CS    <= 1'b1;
      SPI_Clk   <= 1'b0;
      SPI_MOSI  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            shreg     <= frame[N-2:0];
            SPI_MOSI  <= frame[N-1];
            SPI_CS    <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SPI_Clk <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SPI_Clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state <= S_HOLD;
            end else begin
              SPI_MOSI <= shreg[N-2];
              shreg    <= {shreg[N-3:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
              state    <= S_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SPI_Clk <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            SPI_CS   <= 1'b1;
            SPI_MOSI <= 1'b0;
            done     <= 1'b1;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
